// File: rtl/led_rgb_driver.sv
// led_rgb_driver
//   Purpose : three-channel PWM LED driver. Each channel's brightness level
//             fades one step at a time toward full-on or full-off. The target
//             for each channel comes from one bit of a colour code, and the
//             colour code is registered before use.
//   Latency : colour -> target takes 1 cycle. Levels move one step per fade
//             tick. pwm_* are registered one cycle after cnt/level/enable.
//   Flow    : no backpressure; the block free-runs on every clock.
//   Ports   : clk     - single clock, rising edge
//             rst     - synchronous active-high reset
//             enable  - 1 = PWM outputs active, 0 = PWM outputs forced low
//             colour  - colour code: bit0 red, bit1 green, bit2 blue
//             pwm_r/g/b - registered PWM drive per channel
//             busy    - some channel level has not yet reached its target
module led_rgb_driver #(
  parameter int PWM_BITS = 8,    // legal 2..16
  parameter int FADE_DIV = 4     // legal 1..65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [2:0] colour,
  output logic       pwm_r,
  output logic       pwm_g,
  output logic       pwm_b,
  output logic       busy
);

  // Full-brightness level. The PWM period is MAX cycles, so the counter
  // only takes the values 0..MAX-1. Because cnt can never equal MAX,
  // a level of MAX gives an output that is always high.
  localparam logic [PWM_BITS-1:0] MAX      = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'((1 << PWM_BITS) - 2);
  localparam logic [PWM_BITS-1:0] LVL_ONE  = PWM_BITS'(1);

  // The fade divider needs at least one bit, even when FADE_DIV = 1.
  // In that case div stays at 0 and every cycle is a fade tick.
  localparam int                  DIV_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(FADE_DIV - 1);
  localparam logic [DIV_W-1:0]    DIV_ONE  = DIV_W'(1);

  // Channel index 0 = red, 1 = green, 2 = blue. This matches the colour bit order.
  logic [2:0]                colour_q;
  logic [PWM_BITS-1:0]       cnt;
  logic [DIV_W-1:0]          div;
  logic [2:0][PWM_BITS-1:0]  level;
  logic [2:0][PWM_BITS-1:0]  target;
  logic [2:0]                pwm_q;
  logic                      fade_tick;

  // Moves a level one step toward its target and never passes it. The
  // compare happens before the step, so the +1 and -1 can never wrap.
  function automatic logic [PWM_BITS-1:0] step_toward(
    input logic [PWM_BITS-1:0] cur,
    input logic [PWM_BITS-1:0] tgt
  );
    logic [PWM_BITS-1:0] nxt;
    nxt = cur;
    if (cur < tgt) begin
      nxt = cur + LVL_ONE;
    end else if (cur > tgt) begin
      nxt = cur - LVL_ONE;
    end
    return nxt;
  endfunction

  // Targets come only from the registered colour. A colour change
  // therefore retargets every channel on the next cycle, starting from
  // the channel's current level. cnt and div are not touched.
  always_comb begin
    target = '0;
    for (int i = 0; i < 3; i++) begin
      target[i] = colour_q[i] ? MAX : '0;
    end
  end

  assign fade_tick = (div == DIV_LAST);

  // Comparing the packed level and target arrays as whole vectors gives
  // the OR over channels of (level != target).
  assign busy = (level != target);

  always_ff @(posedge clk) begin
    if (rst) begin
      colour_q <= '0;
      cnt      <= '0;
      div      <= '0;
      level    <= '0;
      pwm_q    <= '0;
    end else begin
      colour_q <= colour;
      cnt      <= (cnt == CNT_LAST) ? '0 : cnt + LVL_ONE;
      div      <= fade_tick ? '0 : div + DIV_ONE;
      for (int i = 0; i < 3; i++) begin
        // enable only gates the output. The counters, colour and levels
        // keep running while it is low, so re-enabling resumes cleanly.
        pwm_q[i] <= enable & (cnt < level[i]);
        if (fade_tick) begin
          level[i] <= step_toward(level[i], target[i]);
        end
      end
    end
  end

  assign pwm_r = pwm_q[0];
  assign pwm_g = pwm_q[1];
  assign pwm_b = pwm_q[2];

endmodule

// File: tb/tb_led_rgb_driver.sv
// tb_led_rgb_driver
//   Drives three driver instances from one shared stimulus:
//   a = (8 bits, div 1), b = (8 bits, div 4), c = (4 bits, div 200).
//   Each cycle, a time-based reference model predicts every output.
module tb_led_rgb_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [2:0] colour;
  logic [2:0] pa, pb, pc;
  logic       ba, bb, bc;

  always #5 clk = ~clk;

  led_rgb_driver #(.PWM_BITS(8), .FADE_DIV(1)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .colour(colour),
    .pwm_r(pa[0]), .pwm_g(pa[1]), .pwm_b(pa[2]), .busy(ba));

  led_rgb_driver #(.PWM_BITS(8), .FADE_DIV(4)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .colour(colour),
    .pwm_r(pb[0]), .pwm_g(pb[1]), .pwm_b(pb[2]), .busy(bb));

  led_rgb_driver #(.PWM_BITS(4), .FADE_DIV(200)) dut_c (
    .clk(clk), .rst(rst), .enable(enable), .colour(colour),
    .pwm_r(pc[0]), .pwm_g(pc[1]), .pwm_b(pc[2]), .busy(bc));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model. The PWM counter is (edges since reset) mod MAX.
  // A fade tick happens whenever (edges since reset) mod FADE_DIV equals
  // FADE_DIV-1. Levels move one unit toward 0 or MAX.
  int         m_max [3] = '{255, 255, 15};
  int         m_fd  [3] = '{1, 4, 200};
  int         m_t   [3];
  int         m_cq  [3];
  int         m_lvl [3][3];
  logic [2:0] m_pwm [3];

  function automatic int tgt_of(int k, int c);
    return (((m_cq[k] >> c) & 1) != 0) ? m_max[k] : 0;
  endfunction

  function automatic logic m_busy(int k);
    logic b;
    b = 1'b0;
    for (int c = 0; c < 3; c++) if (m_lvl[k][c] != tgt_of(k, c)) b = 1'b1;
    return b;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_t[k]   = 0;
        m_cq[k]  = 0;
        m_pwm[k] = 3'b000;
        for (int c = 0; c < 3; c++) m_lvl[k][c] = 0;
      end else begin
        int  pos;
        bit  tick;
        pos  = m_t[k] % m_max[k];
        tick = ((m_t[k] % m_fd[k]) == (m_fd[k] - 1));
        for (int c = 0; c < 3; c++) begin
          int tgt;
          tgt = tgt_of(k, c);
          m_pwm[k][c] = enable && (pos < m_lvl[k][c]);
          if (tick) begin
            if (m_lvl[k][c] < tgt) m_lvl[k][c] = m_lvl[k][c] + 1;
            else if (m_lvl[k][c] > tgt) m_lvl[k][c] = m_lvl[k][c] - 1;
          end
        end
        m_cq[k] = int'(colour);
        m_t[k]  = m_t[k] + 1;
      end
    end
  endtask

  function automatic logic [2:0] pwm_of(int k);
    case (k)
      0:       return pa;
      1:       return pb;
      default: return pc;
    endcase
  endfunction

  function automatic logic busy_of(int k);
    case (k)
      0:       return ba;
      1:       return bb;
      default: return bc;
    endcase
  endfunction

  // One clock: advance the model at the edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("pwm_dut%0d", k), pwm_of(k), m_pwm[k]);
      check($sformatf("busy_dut%0d", k), busy_of(k), m_busy(k));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int na, nb, hia, hic, gbz, hi;

    // Reset with white requested and enable high: everything stays low.
    rst    = 1'b1;
    enable = 1'b1;
    colour = 3'b111;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_pwm", {pa, pb, pc}, 0);
      check("rst_busy", {ba, bb, bc}, 0);
    end
    rst    = 1'b0;
    colour = 3'b001;
    #1;
    check("release_pwm", {pa, pb, pc}, 0);
    check("release_busy", {ba, bb, bc}, 0);

    // Full red fade on all instances. Also check duty at fixed levels.
    na = 0; nb = 0; hia = 0; hic = 0; gbz = 0;
    for (int i = 0; i < 1100; i++) begin
      step();
      if (ba) na++;
      if (bb) nb++;
      if (i >= 600 && i < 855) begin
        if (pa[0]) hia++;
        if (pa[1] || pa[2]) gbz++;
      end
      if (i >= 1050 && i < 1065 && pc[0]) hic++;
    end
    check("fade_a_busy_cycles", na, 255);
    check("fade_b_busy_cycles", nb, 1019);
    check("duty_a_full", hia, 255);
    check("gb_a_zero", gbz, 0);
    check("duty_c_level5", hic, 5);
    check("fade_ab_done", {ba, bb}, 0);

    // Reversal: colour_q drops to 000 on the same edge that takes level_r to 100.
    colour = 3'b000;
    do_reset();
    colour = 3'b001;
    repeat (100) step();
    colour = 3'b000;
    na = 0; hi = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (ba) na++;
      if (i >= 150 && pa[0]) hi++;
    end
    check("reverse_busy_cycles", na, 100);
    check("reverse_pwm_low", hi, 0);
    check("reverse_busy_end", ba, 0);

    // Enable gating on fully faded white.
    do_reset();
    colour = 3'b111;
    repeat (1100) step();
    check("white_a_on", pa, 3'b111);
    check("white_busy", {ba, bb}, 0);
    enable = 1'b0;
    #1;
    check("en_fall_hold", pa, 3'b111);
    for (int i = 0; i < 4; i++) begin
      step();
      check("en_off_a", pa, 0);
      check("en_off_b", pb, 0);
      check("en_off_busy", {ba, bb}, 0);
    end
    enable = 1'b1;
    step();
    check("en_on_a", pa, 3'b111);
    check("en_on_b", pb, 3'b111);

    // Divider on green, with reset asserted mid-fade.
    do_reset();
    colour = 3'b010;
    repeat (200) step();
    check("mid_fade_busy_b", bb, 1);
    rst = 1'b1;
    step();
    check("midrst_pwm", {pa, pb, pc}, 0);
    check("midrst_busy", {ba, bb, bc}, 0);
    rst = 1'b0;
    nb = 0;
    for (int i = 0; i < 1100; i++) begin
      step();
      if (bb) nb++;
    end
    check("green_b_busy_cycles", nb, 1019);

    // Random colour, enable and occasional reset, checked by the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) colour = 3'($urandom);
      if ($urandom_range(29) == 0) enable = ~enable;
      rst = ($urandom_range(499) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
